// File: rtl/full_adder_core_if.sv
// Operand/result bundle for full_adder_core: operands and qualifier in, flags and carry-event count out.
interface full_adder_core_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             out_valid;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output a, b, c_in, in_valid,
    input  s, c_out, ovf, zero, out_valid, carry_cnt
  );

  modport slave (
    input  a, b, c_in, in_valid,
    output s, c_out, ovf, zero, out_valid, carry_cnt
  );
endinterface

// File: rtl/full_adder_core.sv
// Ripple-carry adder with overflow/zero flags and a saturating carry-out event counter.
// FULL_ADDER_CORE_PIPE_EN adds a 1-cycle register on the results; otherwise 0-cycle latency, no backpressure.
module full_adder_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  full_adder_core_if.slave bus
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  logic             ovf_comb;
  logic             zero_comb;
  logic             count_evt;
  logic [CNT_W-1:0] carry_cnt_q;

  assign c[0] = bus.c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]   = bus.a[i] ^ bus.b[i] ^ c[i];
    assign c[i+1]   = (bus.a[i] & bus.b[i]) | (c[i] & (bus.a[i] ^ bus.b[i]));
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf_comb  = c[WIDTH] ^ c[WIDTH-1];
  assign zero_comb = ~|sum;

`ifdef FULL_ADDER_CORE_PIPE_EN
  logic [WIDTH-1:0] s_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             zero_q;
  logic             out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= sum;
      c_out_q     <= c[WIDTH];
      ovf_q       <= ovf_comb;
      zero_q      <= zero_comb;
      out_valid_q <= bus.in_valid;
    end
  end

  assign bus.s         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;
  // The counter sees the result one edge after it is presented.
  assign count_evt     = out_valid_q & c_out_q;
`else
  assign bus.s         = sum;
  assign bus.c_out     = c[WIDTH];
  assign bus.ovf       = ovf_comb;
  assign bus.zero      = zero_comb;
  assign bus.out_valid = bus.in_valid & ~rst;
  assign count_evt     = bus.in_valid & c[WIDTH];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_cnt_q <= '0;
    end else if (count_evt && (carry_cnt_q != {CNT_W{1'b1}})) begin
      carry_cnt_q <= carry_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_full_adder_core.sv
// Drives a 1-bit and an 8-bit full_adder_core side by side against an arithmetic reference model.
module tb_full_adder_core;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   exp_cnt1;
  int   exp_cnt8;

  full_adder_core_if #(.WIDTH(1), .CNT_W(8)) if1 ();
  full_adder_core_if #(.WIDTH(8), .CNT_W(8)) if8 ();

  full_adder_core #(.WIDTH(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  full_adder_core #(.WIDTH(8), .CNT_W(8)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, let one edge pass, compare against plain integer arithmetic.
  task automatic apply(input int w, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input logic vl, input string tag);
    longint full, sa, sb, ss, lim, msk;
    logic [7:0] es;
    logic ec, eo, ez;
    @(negedge clk);
    if (w == 1) begin
      if1.a = av[0]; if1.b = bv[0]; if1.c_in = ci; if1.in_valid = vl; if8.in_valid = 1'b0;
    end else begin
      if8.a = av; if8.b = bv; if8.c_in = ci; if8.in_valid = vl; if1.in_valid = 1'b0;
    end
    msk  = (longint'(1) << w) - 1;
    full = (longint'(av) & msk) + (longint'(bv) & msk) + longint'(ci);
    es   = 8'(full & msk);
    ec   = full[w];
    lim  = longint'(1) << (w - 1);
    sa   = (longint'(av) & msk); if (sa >= lim) sa -= (longint'(1) << w);
    sb   = (longint'(bv) & msk); if (sb >= lim) sb -= (longint'(1) << w);
    ss   = sa + sb + longint'(ci);
    eo   = (ss > lim - 1) || (ss < -lim);
    ez   = (es == 8'h00);
    @(posedge clk); #1;
    if (w == 1) begin
      chk({tag, "_s"}, 64'(if1.s), 64'(es));
      chk({tag, "_cout"}, 64'(if1.c_out), 64'(ec));
      chk({tag, "_ovf"}, 64'(if1.ovf), 64'(eo));
      chk({tag, "_zero"}, 64'(if1.zero), 64'(ez));
      chk({tag, "_vld"}, 64'(if1.out_valid), 64'(vl));
      if (vl && ec && exp_cnt1 < 255) exp_cnt1++;
    end else begin
      chk({tag, "_s"}, 64'(if8.s), 64'(es));
      chk({tag, "_cout"}, 64'(if8.c_out), 64'(ec));
      chk({tag, "_ovf"}, 64'(if8.ovf), 64'(eo));
      chk({tag, "_zero"}, 64'(if8.zero), 64'(ez));
      chk({tag, "_vld"}, 64'(if8.out_valid), 64'(vl));
      if (vl && ec && exp_cnt8 < 255) exp_cnt8++;
    end
  endtask

  // Idle edge so a pipelined counter catches up with the last presented result.
  task automatic flush();
    @(negedge clk);
    if1.in_valid = 1'b0;
    if8.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reset with carry-producing operands marked valid: they must be dropped.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    if1.a = 1'b1; if1.b = 1'b1; if1.c_in = 1'b1; if1.in_valid = 1'b1;
    if8.a = 8'h80; if8.b = 8'h80; if8.c_in = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    exp_cnt1 = 0;
    exp_cnt8 = 0;
    chk({tag, "_vld1"}, 64'(if1.out_valid), 64'd0);
    chk({tag, "_vld8"}, 64'(if8.out_valid), 64'd0);
    chk({tag, "_cnt1"}, 64'(if1.carry_cnt), 64'd0);
    chk({tag, "_cnt8"}, 64'(if8.carry_cnt), 64'd0);
`ifdef FULL_ADDER_CORE_PIPE_EN
    chk({tag, "_s8"}, 64'(if8.s), 64'd0);
    chk({tag, "_cout8"}, 64'(if8.c_out), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    if1.in_valid = 1'b0;
    if8.in_valid = 1'b0;
  endtask

  logic [1:0] req_tab [8];
  logic [2:0] v;

  initial begin
    n_cmp = 0; n_bad = 0; exp_cnt1 = 0; exp_cnt8 = 0;
    req_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst = 1'b1;
    if1.a = '0; if1.b = '0; if1.c_in = 1'b0; if1.in_valid = 1'b0;
    if8.a = '0; if8.b = '0; if8.c_in = 1'b0; if8.in_valid = 1'b0;
    repeat (2) @(posedge clk);

    do_reset("reset");
    flush();
    chk("post_reset_cnt1", 64'(if1.carry_cnt), 64'd0);
    chk("post_reset_cnt8", 64'(if8.carry_cnt), 64'd0);

    // Exhaustive 1-bit sweep of {a,b,c_in}.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      apply(1, {7'd0, v[2]}, {7'd0, v[1]}, v[0], 1'b1, $sformatf("sweep%0d", i));
      chk($sformatf("sweep%0d_table", i), 64'({if1.c_out, if1.s}), 64'(req_tab[i]));
    end
    flush();
    chk("sweep_cnt", 64'(if1.carry_cnt), 64'd4);
    chk("sweep_cnt_model", 64'(if1.carry_cnt), 64'(exp_cnt1));

    // Unqualified operands still produce results but are not counted.
    apply(1, 8'd1, 8'd1, 1'b1, 1'b0, "novld");
    flush();
    chk("novld_cnt", 64'(if1.carry_cnt), 64'd4);

    apply(8, 8'hFF, 8'h00, 1'b1, 1'b1, "ff_00_1");
    chk("ff_00_1_zero_const", 64'({if8.c_out, if8.zero, if8.ovf, if8.s}), {53'd0, 3'b110, 8'h00});
    apply(8, 8'h7F, 8'h01, 1'b0, 1'b1, "7f_01_0");
    chk("7f_01_0_const", 64'({if8.c_out, if8.ovf, if8.s}), {54'd0, 2'b01, 8'h80});
    apply(8, 8'h80, 8'h80, 1'b0, 1'b1, "80_80_0");
    chk("80_80_0_const", 64'({if8.c_out, if8.ovf, if8.zero, if8.s}), {53'd0, 3'b111, 8'h00});

    for (int i = 0; i < 40; i++)
      apply(8, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $sformatf("rnd%0d", i));
    flush();
    chk("rnd_cnt8", 64'(if8.carry_cnt), 64'(exp_cnt8));

    // Saturation after a fresh reset.
    do_reset("reset2");
    for (int i = 0; i < 300; i++)
      apply(8, 8'h80, 8'h80, 1'b0, 1'b1, "sat");
    flush();
    chk("sat_cnt", 64'(if8.carry_cnt), 64'd255);
    chk("sat_cnt_model", 64'(if8.carry_cnt), 64'(exp_cnt8));

    // Mid-stream reset, then normal operation on the following cycle.
    apply(8, 8'h12, 8'h34, 1'b0, 1'b1, "pre_rst");
    chk("pre_rst_s_const", 64'(if8.s), 64'h46);
    do_reset("mid_rst");
    apply(8, 8'hF0, 8'h20, 1'b1, 1'b1, "post_rst");
    chk("post_rst_s_const", 64'(if8.s), 64'h11);
    flush();
    chk("post_rst_cnt", 64'(if8.carry_cnt), 64'd1);
    chk("post_rst_cnt1", 64'(if1.carry_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
